// File: rtl/fetch_unit.sv
// fetch_unit: multicycle instruction fetch stage. Holds the PC, fetches one word per
// imem req/ack handshake and redirects on jump/branch. Optional FETCH_TIMEOUT_EN adds an ack timeout.
module fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   output logic [31:0] instr,
   output logic [15:0] imm,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      RST   = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [31:0] pc_nx;
   logic        expired;

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = {pc[31:2], 2'b00};
   assign imm       = instr[15:0];

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;

   // An ack on the limit cycle wins over the timeout.
   assign expired = (state == FETCH) && !imem_ack &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || state != FETCH)
         wait_cnt <= '0;
      else if (!imem_ack)
         wait_cnt <= wait_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         fetch_err <= 1'b0;
      else if (expired)
         fetch_err <= 1'b1;
   end
`else
   assign expired   = 1'b0;
   assign fetch_err = 1'b0;
`endif

   // State register; pc and instr move with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RST;
         pc    <= RESET_PC;
         instr <= '0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (state == FETCH && imem_ack)
            instr <= imem_rdata;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         RST:     state_nx = FETCH;
         FETCH: begin
            if (imem_ack)
               state_nx = ISSUE;
            else if (expired)
               state_nx = HALT;
         end
         ISSUE: begin
            if (!stall)
               state_nx = FETCH;
         end
         default: state_nx = state;
      endcase
   end

   // Redirect is taken only when the issued instruction is consumed.
   always_comb begin
      pc_nx = pc;
      if (state == ISSUE && !stall) begin
         if (jump)
            pc_nx = {pc_plus4[31:28], jump_target, 2'b00};
         else if (branch_taken)
            pc_nx = pc_plus4 + (branch_offset << 2);
         else
            pc_nx = pc_plus4;
      end
   end

   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state)
         FETCH:   imem_req    = 1'b1;
         ISSUE:   instr_valid = 1'b1;
         default: ;
      endcase
   end

endmodule
